key_poll_master: RTL

Avalon-MM master that periodically reads a key input PIO data register (offset 0), debounces the sampled bits, and presents a stable key state, one-cycle press pulses and an optional interrupt to fabric logic. It is the initiator counterpart of the read-only key PIO slaves in the SoC. It connects to the same interconnect as the CPU and gives hardware (game/FSM logic) key events without software polling.

---
 rtl/key_poll_master.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/key_poll_master.sv
// Avalon-MM master that polls a key PIO data register, debounces the bits and
// emits stable key state, press pulses and (with KEY_POLL_IRQ_EN) a level irq.
module key_poll_master #(
  parameter int unsigned       WIDTH      = 2,
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = {ADDR_W{1'b0}},
  parameter int unsigned       POLL_DIV   = 50000,
  parameter int unsigned       DEBOUNCE_N = 4,
  parameter int unsigned       TIMEOUT    = 255,
  parameter bit                ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [WIDTH-1:0]  key_state,
  output logic [WIDTH-1:0]  key_press,
  output logic              poll_err,
  output logic              irq,
  input  logic              irq_ack
);

  localparam int unsigned      PD_W     = $clog2(POLL_DIV);
  localparam int unsigned      TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PD_W-1:0]  PD_LAST  = PD_W'(POLL_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [3:0]       DB_N     = 4'(DEBOUNCE_N);
  localparam logic [WIDTH-1:0] INV_MASK = ACTIVE_LOW ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT   = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PD_W-1:0]  r_poll_cnt;
  logic             r_due;
  logic [TO_W-1:0]  r_to_cnt;
  logic [WIDTH-1:0] r_sample;
  logic [WIDTH-1:0] r_cand;
  logic [3:0]       r_stable_cnt;
  logic [WIDTH-1:0] r_key_state;
  logic [WIDTH-1:0] r_key_press;
  logic             r_read;
  logic             r_poll_err;

  logic             w_tc;
  logic             w_accept;
  logic             w_capture;
  logic             w_timeout;
  logic             w_read_nxt;
  logic             w_err_nxt;
  logic [WIDTH-1:0] w_cand_nxt;
  logic [3:0]       w_stable_nxt;
  logic [WIDTH-1:0] w_key_nxt;
  logic [WIDTH-1:0] w_press_nxt;
  logic             w_unused_ok;

  assign w_tc      = (r_poll_cnt == PD_LAST);
  assign w_accept  = (r_state == S_REQ) && !avm_waitrequest;
  assign w_capture = (w_accept || (r_state == S_WAIT)) && avm_readdatavalid;
  assign w_timeout = (r_state == S_WAIT) && !avm_readdatavalid && (r_to_cnt == TO_LAST);

  // Poll counter free-runs so the period is independent of fabric latency;
  // a wrap seen outside IDLE is remembered once (missed polls are not queued).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_poll_cnt <= {PD_W{1'b0}};
      r_due      <= 1'b0;
      r_to_cnt   <= {TO_W{1'b0}};
      r_sample   <= {WIDTH{1'b0}};
    end else begin
      r_poll_cnt <= w_tc ? {PD_W{1'b0}} : r_poll_cnt + PD_W'(1);
      if (r_state == S_IDLE)  r_due <= 1'b0;
      else if (w_tc)          r_due <= 1'b1;
      if (w_accept)                 r_to_cnt <= {TO_W{1'b0}};
      else if (r_state == S_WAIT)   r_to_cnt <= r_to_cnt + TO_W'(1);
      if (w_capture) r_sample <= avm_readdata[WIDTH-1:0] ^ INV_MASK;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = (w_tc || r_due) ? S_REQ : S_IDLE;
      S_REQ: begin
        if (!avm_waitrequest) w_state_nxt = avm_readdatavalid ? S_UPDATE : S_WAIT;
        else                  w_state_nxt = S_REQ;
      end
      S_WAIT: begin
        if (avm_readdatavalid) w_state_nxt = S_UPDATE;
        else if (w_timeout)    w_state_nxt = S_IDLE;
        else                   w_state_nxt = S_WAIT;
      end
      S_UPDATE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_read_nxt = (w_state_nxt == S_REQ);
    w_err_nxt  = w_timeout;
  end

  // Debounce: a new value must repeat DEBOUNCE_N polls before it is accepted.
  always_comb begin
    w_cand_nxt   = r_cand;
    w_stable_nxt = r_stable_cnt;
    w_key_nxt    = r_key_state;
    if (r_state == S_UPDATE) begin
      if (r_sample == r_cand) begin
        if (r_stable_cnt < DB_N) w_stable_nxt = r_stable_cnt + 4'd1;
        else                     w_stable_nxt = r_stable_cnt;
      end else begin
        w_cand_nxt   = r_sample;
        w_stable_nxt = 4'd1;
      end
      if (w_stable_nxt >= DB_N) w_key_nxt = w_cand_nxt;
      else                      w_key_nxt = r_key_state;
    end else begin
      w_key_nxt = r_key_state;
    end
    w_press_nxt = w_key_nxt & ~r_key_state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_read       <= 1'b0;
      r_poll_err   <= 1'b0;
      r_cand       <= {WIDTH{1'b0}};
      r_stable_cnt <= 4'd0;
      r_key_state  <= {WIDTH{1'b0}};
      r_key_press  <= {WIDTH{1'b0}};
    end else begin
      r_read       <= w_read_nxt;
      r_poll_err   <= w_err_nxt;
      r_cand       <= w_cand_nxt;
      r_stable_cnt <= w_stable_nxt;
      r_key_state  <= w_key_nxt;
      r_key_press  <= w_press_nxt;
    end
  end

`ifdef KEY_POLL_IRQ_EN
  logic r_irq;

  // A new press wins over a simultaneous acknowledge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          r_irq <= 1'b0;
    else if (|w_press_nxt) r_irq <= 1'b1;
    else if (irq_ack)      r_irq <= 1'b0;
    else                   r_irq <= r_irq;
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  assign w_unused_ok = ^{irq_ack, avm_readdata};
  assign avm_address = BASE_ADDR;
  assign avm_read    = r_read;
  assign poll_err    = r_poll_err;
  assign key_state   = r_key_state;
  assign key_press   = r_key_press;

endmodule
